bus_arbiter: RTL
================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 8, SHALL set the maximum consecutive cycles one requester owns the bus while another requester is waiting; legal range 2..255.
REQ-002 Port Clk  input  1  SHALL be the single system clock; all state updates occur on its rising edge.
REQ-003 Port Reset  input  1  SHALL be an asynchronous, active-low reset.
REQ-004 Port Req  input  4  SHALL carry bus requests, one bit per source: bit0=PC, bit1=MDR, bit2=ALU, bit3=MARMUX.
REQ-005 Ports GatePC, GateMDR, GateALU, GateMARMUX  output  1 each  SHALL be the registered bus-drive enables for the 16-bit bus mux.
REQ-006 Port Owner  output  2  SHALL give the index of the current grantee; valid only while Busy=1.
REQ-007 Port Busy  output  1  SHALL be 1 exactly when any Gate* output is 1.
REQ-008 Port Preempt  output  1  SHALL pulse high for one cycle on a forced release (see REQ-016).

Function
REQ-009 The Gate* outputs SHALL be registered and at most one-hot; two gates high in the same cycle is illegal.
REQ-010 The FSM SHALL have exactly three states: IDLE, GRANT and TURN.
REQ-011 IDLE behaviour: if Req!=0 at the edge, the arbiter SHALL select the first set bit found scanning upward from rr_ptr (mod 4), assert that gate, load Owner and move to GRANT; if Req=0, it SHALL stay in IDLE.
REQ-012 Grant latency SHALL be 1 cycle: a request sampled at edge k in IDLE has its gate high from edge k to edge k+1 onward.
REQ-013 GRANT behaviour: a hold counter (8-bit) SHALL be cleared on grant and increment every cycle the grant is held.
REQ-014 If Req[Owner] is sampled 0 in GRANT, the arbiter SHALL drop all gates at that edge, set rr_ptr=Owner+1 (mod 4) and go to TURN.
REQ-015 TURN SHALL last exactly one cycle with all gates 0 (bus turnaround); on its exiting edge it SHALL arbitrate exactly as IDLE, going to GRANT if Req!=0 and to IDLE otherwise.
REQ-016 Forced release: if the hold counter equals MAX_HOLD-1, Req[Owner]=1 and any other Req bit=1, the arbiter SHALL drop the gates, pulse Preempt, set rr_ptr=Owner+1 and go to TURN.
REQ-017 If the hold counter reaches MAX_HOLD-1 with no other requester pending, the arbiter SHALL keep the grant and restart the counter at 0 (no forced release, no Preempt).
REQ-018 A new request arriving in GRANT SHALL NOT change the current grant until REQ-014 or REQ-016 fires.
REQ-019 The owner dropping its request on the same edge that the forced-release condition would fire SHALL be treated as a normal release (REQ-014), with Preempt=0.
REQ-020 Fairness: with all four requests held continuously, ownership SHALL rotate PC, MDR, ALU, MARMUX, PC, ... with exactly one TURN cycle between owners.

Reset
REQ-021 Reset=0 SHALL immediately, without waiting for a clock edge, force state=IDLE, all Gate*=0, Busy=0, Preempt=0, Owner=0, rr_ptr=0 and hold counter=0.
REQ-022 Reset asserted mid-grant SHALL drop the gate asynchronously; after release, the first arbitration SHALL start from rr_ptr=0 (PC has first priority).
REQ-023 Reset deassertion SHALL take effect from the first rising edge after release; Req sampled at that edge SHALL be arbitrated per REQ-011.

Verification
REQ-024 After reset, apply Req=0110 at edge 1 -> GateMDR=1, Owner=1, Busy=1 after edge 1; GateALU stays 0.
REQ-025 Drop Req[1] while holding Req=0100 -> at the next edge all gates=0 (TURN), then GateALU=1 with Owner=2 after the following edge.
REQ-026 Use MAX_HOLD=4 with Req=1001 held continuously -> GatePC high for 4 cycles, Preempt=1 for one cycle with gates 0, then GateMARMUX high for 4 cycles, repeating.
REQ-027 Use Req=0001 held continuously for 20 cycles -> GatePC stays high throughout and Preempt stays 0 (exercises REQ-017).
REQ-028 Use Req=1111 held continuously -> Owner sequence 0,1,2,3,0 with one gate-free cycle between owners, and never more than one Gate* high in any cycle.
REQ-029 Pulse Reset=0 between clock edges during a GateALU grant -> GateALU falls immediately; after release with Req=1111, GatePC is granted first.

Source files
------------

// File: rtl/bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// bus_arbiter_if : request/gate bundle between bus sources and the arbiter
// Revision: 1.0
// ============================================================================
interface bus_arbiter_if;
    logic [3:0] Req;
    logic       GatePC;
    logic       GateMDR;
    logic       GateALU;
    logic       GateMARMUX;
    logic [1:0] Owner;
    logic       Busy;
    logic       Preempt;

    modport master (
        input  Req,
        output GatePC, GateMDR, GateALU, GateMARMUX, Owner, Busy, Preempt
    );

    modport slave (
        output Req,
        input  GatePC, GateMDR, GateALU, GateMARMUX, Owner, Busy, Preempt
    );
endinterface
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// bus_arbiter : round-robin owner of a 4-source bus mux with hold-time preemption
// Revision: 1.0
// ============================================================================
module bus_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  wire logic      Clk,
    input  wire logic      Reset,
    bus_arbiter_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_t;

    localparam logic [7:0] c_hold_last = 8'(MAX_HOLD - 1);

    state_t     r_state,   w_state_nxt;
    logic [3:0] r_gate,    w_gate_nxt;
    logic [1:0] r_owner,   w_owner_nxt;
    logic [1:0] r_rr_ptr,  w_rr_ptr_nxt;
    logic [7:0] r_hold,    w_hold_nxt;
    logic       r_preempt, w_preempt_nxt;

    logic [7:0] w_req2;
    logic [3:0] w_rot;
    logic [1:0] w_off;
    logic [1:0] w_pick;
    logic       w_own_req;
    logic       w_others;

    // Rotate requests so bit 0 is rr_ptr; lowest set bit is the next owner.
    assign w_req2    = {bus.Req, bus.Req};
    assign w_rot     = w_req2[r_rr_ptr +: 4];
    assign w_pick    = r_rr_ptr + w_off;
    assign w_own_req = bus.Req[r_owner];
    assign w_others  = |(bus.Req & ~r_gate);

    always_comb begin
        w_off = 2'd3;
        if (w_rot[0])      w_off = 2'd0;
        else if (w_rot[1]) w_off = 2'd1;
        else if (w_rot[2]) w_off = 2'd2;
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_gate_nxt    = r_gate;
        w_owner_nxt   = r_owner;
        w_rr_ptr_nxt  = r_rr_ptr;
        w_hold_nxt    = r_hold;
        w_preempt_nxt = 1'b0;
        case (r_state)
            IDLE, TURN: begin
                if (|bus.Req) begin
                    w_state_nxt = GRANT;
                    w_gate_nxt  = 4'b0001 << w_pick;
                    w_owner_nxt = w_pick;
                    w_hold_nxt  = 8'd0;
                end else begin
                    w_state_nxt = IDLE;
                    w_gate_nxt  = 4'b0000;
                end
            end
            GRANT: begin
                // An owner dropping its request always wins over preemption.
                if (!w_own_req) begin
                    w_state_nxt  = TURN;
                    w_gate_nxt   = 4'b0000;
                    w_rr_ptr_nxt = r_owner + 2'd1;
                end else if (r_hold == c_hold_last) begin
                    if (w_others) begin
                        w_state_nxt   = TURN;
                        w_gate_nxt    = 4'b0000;
                        w_preempt_nxt = 1'b1;
                        w_rr_ptr_nxt  = r_owner + 2'd1;
                    end else begin
                        w_hold_nxt = 8'd0;
                    end
                end else begin
                    w_hold_nxt = r_hold + 8'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_gate_nxt  = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state   <= IDLE;
            r_gate    <= 4'b0000;
            r_owner   <= 2'd0;
            r_rr_ptr  <= 2'd0;
            r_hold    <= 8'd0;
            r_preempt <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_gate    <= w_gate_nxt;
            r_owner   <= w_owner_nxt;
            r_rr_ptr  <= w_rr_ptr_nxt;
            r_hold    <= w_hold_nxt;
            r_preempt <= w_preempt_nxt;
        end
    end

    assign bus.GatePC     = r_gate[0];
    assign bus.GateMDR    = r_gate[1];
    assign bus.GateALU    = r_gate[2];
    assign bus.GateMARMUX = r_gate[3];
    assign bus.Owner      = r_owner;
    assign bus.Busy       = |r_gate;
    assign bus.Preempt    = r_preempt;

endmodule
`default_nettype wire
